// File: rtl/hash_resp_pkg.sv
// rtl/hash_resp_pkg.sv - shared definitions for the hash response buffer
// Purpose: response-word flag offsets, flag struct and word-width helper.
// Ports: none (package).
package hash_resp_pkg;

  localparam int FLAG_COUNT = 4;

  // Flag positions expressed as distance below the word width W:
  // a flag sits at bit W - <OFS>.
  localparam int DUP_OFS      = 1;  // key_already_present
  localparam int NOTFOUND_OFS = 2;  // no_element_found
  localparam int FULL_OFS     = 3;  // no_write_space
  localparam int NODEL_OFS    = 4;  // no_deletion_target

  // Packed so that the MSB-first field order matches the word's top bits.
  typedef struct packed {
    logic dup;
    logic notfound;
    logic full;
    logic nodel;
  } resp_flags_t;

  function automatic int resp_width(input int key_w, input int data_w);
    return key_w + data_w + 2;
  endfunction

endpackage

// File: rtl/hash_resp_fifo.sv
// rtl/hash_resp_fifo.sv - first-word-fall-through beat FIFO
// Purpose: storage, wrapping pointers and occupancy for the response buffer.
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-low reset
//   wr_data/valid/ready   - write side; ready depends on registered state only
//   rd_data/valid/ready   - read side; rd_data is the head entry, zero when empty
//   level                 - current occupancy, 0..DEPTH
module hash_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    lvl;
  logic             run;
  logic             push;
  logic             pop;

  // run holds ready low during reset and rises on the first edge after release.
  assign wr_ready = run && (lvl < LW'(DEPTH));
  assign rd_valid = (lvl != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign level    = lvl;

  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid && rd_ready;

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
  // the natural overflow the modulo wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible after it is written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/hash_resp_buffer.sv
// rtl/hash_resp_buffer.sv - response buffer with flag statistics
// Purpose: buffers hash-table response beats and counts flagged responses.
// Optional feature macro: HASH_RESP_STATS_EN (statistics counters and clear).
// Ports:
//   clk, reset                  - rising-edge clock, asynchronous active-low reset
//   s_data_i/valid/last/keep    - input beat, s_ready_o handshake
//   m_data_o/valid/last/keep    - head beat, m_ready_i handshake; m_err_o = OR of head flags
//   clear_stats_i               - synchronous counter clear (priority over increment)
//   level_o                     - buffer occupancy
//   cnt_dup/notfound/full/nodel - saturating per-flag counters
import hash_resp_pkg::*;

module hash_resp_buffer #(
  parameter int KEY_WIDTH  = 5,
  parameter int DATA_WIDTH = 25,
  parameter int KEEP_WIDTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [resp_width(KEY_WIDTH, DATA_WIDTH)-1:0] s_data_i,
  input  logic                                        s_valid_i,
  input  logic                                        s_last_i,
  input  logic [KEEP_WIDTH-1:0]                       s_keep_i,
  output logic                                        s_ready_o,
  output logic [resp_width(KEY_WIDTH, DATA_WIDTH)-1:0] m_data_o,
  output logic                                        m_valid_o,
  output logic                                        m_last_o,
  output logic [KEEP_WIDTH-1:0]                       m_keep_o,
  output logic                                        m_err_o,
  input  logic                                        m_ready_i,
  input  logic                                        clear_stats_i,
  output logic [$clog2(FIFO_DEPTH):0]                 level_o,
  output logic [CNT_WIDTH-1:0]                        cnt_dup_o,
  output logic [CNT_WIDTH-1:0]                        cnt_notfound_o,
  output logic [CNT_WIDTH-1:0]                        cnt_full_o,
  output logic [CNT_WIDTH-1:0]                        cnt_nodel_o
);

  localparam int W  = resp_width(KEY_WIDTH, DATA_WIDTH);
  localparam int FW = W + 1 + KEEP_WIDTH;

  logic [FW-1:0] rd_word;

  hash_resp_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_data  ({s_data_i, s_last_i, s_keep_i}),
    .wr_valid (s_valid_i),
    .wr_ready (s_ready_o),
    .rd_data  (rd_word),
    .rd_valid (m_valid_o),
    .rd_ready (m_ready_i),
    .level    (level_o)
  );

  // The FIFO zeroes its head word when empty, so these are all 0 then.
  assign m_data_o = rd_word[FW-1 -: W];
  assign m_last_o = rd_word[KEEP_WIDTH];
  assign m_keep_o = rd_word[KEEP_WIDTH-1:0];
  assign m_err_o  = |m_data_o[W-1 -: FLAG_COUNT];

`ifdef HASH_RESP_STATS_EN
  resp_flags_t              flags;
  logic [FLAG_COUNT-1:0]    flag_vec;
  logic                     accept;
  logic [CNT_WIDTH-1:0]     cnt [FLAG_COUNT];

  assign flags.dup      = s_data_i[W-DUP_OFS];
  assign flags.notfound = s_data_i[W-NOTFOUND_OFS];
  assign flags.full     = s_data_i[W-FULL_OFS];
  assign flags.nodel    = s_data_i[W-NODEL_OFS];
  assign flag_vec       = flags;
  assign accept         = s_valid_i && s_ready_o;

  for (genvar i = 0; i < FLAG_COUNT; i++) begin : g_cnt
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt[i] <= '0;
      end else if (clear_stats_i) begin
        cnt[i] <= '0;
      end else if (accept && flag_vec[i] && (cnt[i] != '1)) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // flag_vec index follows the struct: dup is the MSB.
  assign cnt_dup_o      = cnt[3];
  assign cnt_notfound_o = cnt[2];
  assign cnt_full_o     = cnt[1];
  assign cnt_nodel_o    = cnt[0];
`else
  logic unused_clear;
  assign unused_clear   = clear_stats_i;
  assign cnt_dup_o      = '0;
  assign cnt_notfound_o = '0;
  assign cnt_full_o     = '0;
  assign cnt_nodel_o    = '0;
`endif

endmodule

// File: tb/tb_hash_resp_buffer.sv
// tb/tb_hash_resp_buffer.sv - self-checking bench for hash_resp_buffer
module tb_hash_resp_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
`ifdef HASH_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [3:0]    s_keep = '0;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_last;
  logic [3:0]    m_keep;
  logic          m_err;
  logic          m_ready = 1'b0;
  logic          clear = 1'b0;
  logic [2:0]    level;
  logic [CW-1:0] cnt_dup, cnt_notfound, cnt_full, cnt_nodel;

  hash_resp_buffer #(
    .KEY_WIDTH(5), .DATA_WIDTH(25), .KEEP_WIDTH(4), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_keep_i(s_keep),
    .s_ready_o(s_ready),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_last_o(m_last), .m_keep_o(m_keep),
    .m_err_o(m_err), .m_ready_i(m_ready),
    .clear_stats_i(clear), .level_o(level),
    .cnt_dup_o(cnt_dup), .cnt_notfound_o(cnt_notfound),
    .cnt_full_o(cnt_full), .cnt_nodel_o(cnt_nodel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [3:0]   keep;
  } beat_t;

  beat_t q[$];
  int    mcnt[4];   // 0 dup, 1 notfound, 2 full, 3 nodel
  bit    run;
  int    compared;
  int    mismatched;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a bounded queue plus saturating flag counters.
  task automatic model_update();
    bit    do_push, do_pop;
    beat_t b;
    if (!reset) begin
      q.delete();
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
      run = 1'b0;
      return;
    end
    do_push = s_valid && run && (q.size() < DEPTH);
    do_pop  = m_ready && (q.size() > 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      b.data = s_data; b.last = s_last; b.keep = s_keep;
      q.push_back(b);
    end
    for (int i = 0; i < 4; i++) begin
      if (clear) mcnt[i] = 0;
      else if (do_push && s_data[W-1-i] && mcnt[i] < (1 << CW) - 1) mcnt[i]++;
    end
    run = 1'b1;
  endtask

  task automatic compare();
    bit ev;
    ev = (q.size() != 0);
    chk("s_ready", s_ready, run && (q.size() < DEPTH));
    chk("m_valid", m_valid, ev);
    chk("level", level, q.size());
    if (ev) begin
      chk("m_data", m_data, q[0].data);
      chk("m_last", m_last, q[0].last);
      chk("m_keep", m_keep, q[0].keep);
      chk("m_err", m_err, |q[0].data[W-1 -: 4]);
    end else begin
      chk("m_data_idle", m_data, 0);
      chk("m_last_idle", m_last, 0);
      chk("m_keep_idle", m_keep, 0);
      chk("m_err_idle", m_err, 0);
    end
    chk("cnt_dup", cnt_dup, STATS ? mcnt[0] : 0);
    chk("cnt_notfound", cnt_notfound, STATS ? mcnt[1] : 0);
    chk("cnt_full", cnt_full, STATS ? mcnt[2] : 0);
    chk("cnt_nodel", cnt_nodel, STATS ? mcnt[3] : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic l, input logic [3:0] k);
    s_valid = v; s_data = d; s_last = l; s_keep = k;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    run = 1'b0;
    for (int i = 0; i < 4; i++) mcnt[i] = 0;

    // Reset state
    repeat (3) step();
    chk("reset_level", level, 0);
    reset = 1'b1;
    step();
    chk("ready_after_release", s_ready, 1);

    // Fill and stall
    m_ready = 1'b0;
    drive(1, 32'h0000_1001, 0, 4'hf); step();
    chk("latency_valid", m_valid, 1);
    drive(1, 32'h0000_2002, 0, 4'h3); step();
    drive(1, 32'h0000_3003, 0, 4'h1); step();
    drive(1, 32'h0000_4004, 1, 4'h7); step();
    chk("full_level", level, 4);
    chk("full_sready", s_ready, 0);
    chk("full_head", m_data, 32'h0000_1001);
    drive(1, 32'h0000_5005, 1, 4'h1); step();   // rejected while full
    drive(0, '0, 0, 4'h0); step();
    chk("stall_head_keep", m_keep, 4'hf);
    m_ready = 1'b1;
    step();
    chk("drain_second", m_data, 32'h0000_2002);
    repeat (4) step();
    chk("drained_level", level, 0);

    // Flags
    drive(1, 32'h4000_0123, 1, 4'h1); step();
    chk("notfound_err", m_err, 1);
    chk("notfound_cnt", cnt_notfound, STATS ? 1 : 0);
    drive(1, 32'h0000_0456, 0, 4'h2); step();
    chk("clean_err", m_err, 0);
    chk("clean_cnt", cnt_notfound, STATS ? 1 : 0);
    drive(0, '0, 0, 4'h0); step();

    // Simultaneous push and pop across pointer wrap
    m_ready = 1'b0;
    drive(1, 32'h000A_0000, 0, 4'h5); step();
    drive(1, 32'h000A_0001, 0, 4'h6); step();
    m_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      drive(1, 32'h000A_0000 + i, (i == 11), 4'(i));
      step();
    end
    chk("pp_level", level, 2);
    chk("pp_head", m_data, 32'h000A_000A);
    drive(0, '0, 0, 4'h0);
    repeat (3) step();

    // Saturation and clear
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h8000_0000 + i, 0, 4'h8);
      step();
    end
    chk("dup_saturated", cnt_dup, STATS ? 15 : 0);
    clear = 1'b1;
    drive(1, 32'h8000_0100, 0, 4'h8); step();
    chk("dup_cleared", cnt_dup, 0);
    clear = 1'b0;
    drive(0, '0, 0, 4'h0);
    repeat (2) step();

    // Reset mid-stream with three beats buffered
    m_ready = 1'b0;
    drive(1, 32'h2000_0001, 0, 4'h1); step();
    drive(1, 32'h1000_0002, 0, 4'h2); step();
    drive(1, 32'h4000_0003, 0, 4'h3); step();
    chk("pre_reset_level", level, 3);
    reset = 1'b0;
    step();
    chk("mid_reset_level", level, 0);
    chk("mid_reset_valid", m_valid, 0);
    chk("mid_reset_cnt_nodel", cnt_nodel, 0);
    reset = 1'b1;
    drive(0, '0, 0, 4'h0);
    step();
    chk("ready_after_mid_reset", s_ready, 1);
    chk("level_after_mid_reset", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hash_resp_buffer.md
HASH_RESP_BUFFER -- requirements
Module: hash_resp_buffer

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 5, key field width of the response word.
REQ-002 SHALL have parameter DATA_WIDTH, default 25, read-data field width.
REQ-003 SHALL have parameter KEEP_WIDTH, default 4, AXI-stream keep width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, number of buffered beats; power of two, at least 2.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, width of each statistics counter.
REQ-006 SHALL use one clock; reset is asynchronous and active-low: port clk input 1, rising-edge clock; port reset input 1, asynchronous active-low reset.
REQ-007 SHALL have ports s_data_i input W=KEY_WIDTH+DATA_WIDTH+2, response word from the hash table wrapper; s_valid_i input 1; s_last_i input 1; s_keep_i input KEEP_WIDTH; s_ready_o output 1.
REQ-008 SHALL have ports m_data_o output W; m_valid_o output 1; m_last_o output 1; m_keep_o output KEEP_WIDTH; m_err_o output 1, OR of the four flags of the head word; m_ready_i input 1.
REQ-009 SHALL have ports clear_stats_i input 1, synchronous statistics clear; level_o output clog2(FIFO_DEPTH)+1, current occupancy.
REQ-010 SHALL have ports cnt_dup_o, cnt_notfound_o, cnt_full_o and cnt_nodel_o, each an output of CNT_WIDTH.

Function
REQ-011 SHALL decode the input word as: [DATA_WIDTH-1:0] read data; bit W-1 key_already_present; bit W-2 no_element_found; bit W-3 no_write_space; bit W-4 no_deletion_target; all remaining bits zero.
REQ-012 SHALL accept an input beat when s_valid_i && s_ready_o, storing {data, last, keep} at the write pointer.
REQ-013 SHALL drive s_ready_o = (level < FIFO_DEPTH) from registered state only, with no combinational path from m_ready_i.
REQ-014 SHALL be a first-word-fall-through FIFO: m_valid_o = (level != 0), and m_data_o/m_last_o/m_keep_o/m_err_o present the head entry.
REQ-015 SHALL pop the head when m_valid_o && m_ready_i; m_* outputs SHALL hold steady while m_valid_o && !m_ready_i.
REQ-016 SHALL give a minimum latency of one cycle: a beat accepted into an empty FIFO at edge N is valid on m_* after edge N.
REQ-017 SHALL handle push and pop in the same cycle: level unchanged, both pointers advance; when full with a pop, s_ready_o is still 0 that cycle (no push).
REQ-018 SHALL let read and write pointers wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH or go below 0.
REQ-019 SHALL increment each counter by 1 on an accepted input beat whose corresponding flag is 1, saturating at all-ones.
REQ-020 SHALL give clear_stats_i priority over increment: the counter reads 0 on the next cycle even if a flagged beat was accepted.
REQ-021 SHALL pass s_last_i and s_keep_i through unmodified with their beat.

Reset
REQ-022 SHALL, while reset=0, asynchronously clear the pointers, level_o and all counters to 0, and force m_valid_o=0, s_ready_o=0, m_err_o=0, m_last_o=0, m_keep_o=0 and m_data_o=0.
REQ-023 SHALL drive s_ready_o=1 on the first edge after reset release; beats in flight at reset SHALL be discarded.

Configuration
REQ-024 SHALL compile the statistics counters and clear_stats_i logic when macro HASH_RESP_STATS_EN is defined.
REQ-025 SHALL, without HASH_RESP_STATS_EN, tie the cnt_* outputs to 0, ignore clear_stats_i, and keep FIFO behaviour identical.

Structure
REQ-026 SHALL place the flag bit-offset constants, the response-word width function and a resp_flags_t struct in package hash_resp_pkg.
REQ-027 SHALL use one sub-module, hash_resp_fifo, for the storage, pointers and level; counters and flag decode SHALL live in the top.

Verification
REQ-028 SHALL verify reset: assert reset=0 mid-stream with 3 beats buffered -> next cycle level_o=0, m_valid_o=0, counters 0; s_ready_o=1 after release.
REQ-029 SHALL verify fill and stall: push 4 beats with m_ready_i=0 -> s_ready_o=0 after 4th, level_o=4; release m_ready_i -> beats out in order, each held stable while stalled.
REQ-030 SHALL verify simultaneous push and pop: FIFO at level 2, push and pop each cycle for 10 cycles -> level_o stays 2, order preserved across pointer wrap.
REQ-031 SHALL verify flags: beat with bit W-2 set -> m_err_o=1 on that beat, cnt_notfound_o=1; flag-free beat -> m_err_o=0, counters unchanged.
REQ-032 SHALL verify saturation and clear: CNT_WIDTH=4, 20 key_already_present beats -> cnt_dup_o=15; clear_stats_i with a flagged beat in the same cycle -> 0.
REQ-033 SHALL verify the macro: build without HASH_RESP_STATS_EN, repeat REQ-031 -> cnt_* = 0, FIFO output identical.
